// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, register-index width,
// hazard FSM states and the ID/EX payload record.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned RIDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } state_e;

  // Control fields derived from one instruction word.
  typedef struct packed {
    logic [RIDX_W-1:0] dest;
    logic              we;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
    logic              rt_used;
  } dec_t;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic              valid;
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   reg_a;
    logic [XLEN-1:0]   reg_b;
    logic [RIDX_W-1:0] dest;
    logic              we;
    logic              mem_read;
    logic              mem_write;
    logic              illegal;
  } idex_t;

  // Classify an instruction from its opcode, funct, rt and rd fields.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct,
                                  input logic [RIDX_W-1:0] rt, input logic [RIDX_W-1:0] rd);
    dec_t d;
    logic legal;
    logic wr_rd;
    logic wr_rt;
    d     = '0;
    legal = 1'b0;
    wr_rd = 1'b0;
    wr_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.rt_used = 1'b1;
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: begin
            legal = 1'b1;
            wr_rd = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        legal = 1'b1;
        wr_rt = 1'b1;
      end
      OP_LW: begin
        legal      = 1'b1;
        wr_rt      = 1'b1;
        d.mem_read = 1'b1;
      end
      OP_SW: begin
        legal       = 1'b1;
        d.rt_used   = 1'b1;
        d.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        legal     = 1'b1;
        d.rt_used = 1'b1;
      end
      default: ;
    endcase
    if (wr_rd)      d.dest = rd;
    else if (wr_rt) d.dest = rt;
    d.we      = (wr_rd || wr_rt) && (d.dest != '0);
    d.illegal = !legal;
    return d;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Architectural register file: two async read ports, one sync write port,
// register 0 reads as zero, same-cycle write is visible to readers.
module reg_file_2r1w
  import mips_pkg::*;
#(
  parameter int unsigned DW    = XLEN,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DW-1:0]            rdata_a,
  output logic [DW-1:0]            rdata_b
);

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic          wr_en_c;

  assign wr_en_c = we && (waddr != '0);

  // Next register contents: single write, register 0 never written.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_c) regs_d[waddr] = wdata;
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // Read ports with write-before-read bypass.
  always_comb begin
    rdata_a = regs_q[raddr_a];
    rdata_b = regs_q[raddr_b];
    if (wr_en_c && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_en_c && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes the fetched word, reads and forwards operands,
// inserts a bubble on load-use hazards and drives the ID/EX register.
module id_issue_stage
  import mips_pkg::*;
#(
  parameter int unsigned     NREGS     = 32,
  parameter logic [ILEN-1:0] RST_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [ILEN-1:0]   if_instr,
  output logic              if_ready,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              mem_we,
  input  logic [RIDX_W-1:0] mem_waddr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              wb_we,
  input  logic [RIDX_W-1:0] wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata,
  output logic              ex_valid,
  output logic [ILEN-1:0]   ex_instr,
  output logic [XLEN-1:0]   ex_reg_a,
  output logic [XLEN-1:0]   ex_reg_b,
  output logic [RIDX_W-1:0] ex_dest,
  output logic              ex_we,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_illegal
);

  localparam idex_t IDEX_RST = idex_t'({1'b0, RST_INSTR, {(2*XLEN + RIDX_W + 4){1'b0}}});

  state_e            state_q, state_d;
  logic [ILEN-1:0]   hold_q, hold_d;
  idex_t             ex_q, ex_d;

  logic [ILEN-1:0]   id_instr_c;
  logic [RIDX_W-1:0] rs_c, rt_c;
  dec_t              dec_c;
  logic [XLEN-1:0]   rf_a_c, rf_b_c;
  logic [XLEN-1:0]   opnd_a_c, opnd_b_c;
  idex_t             issue_c;
  logic              stall_c, accept_c, lu_hazard_c;

  // Word in decode: the held word while recovering from a load-use bubble.
  assign id_instr_c = (state_q == ST_LU_STALL) ? hold_q : if_instr;
  assign rs_c       = id_instr_c[25:21];
  assign rt_c       = id_instr_c[20:16];
  assign dec_c      = decode(id_instr_c[31:26], id_instr_c[5:0], rt_c, id_instr_c[15:11]);

  assign stall_c  = ex_q.valid && !ex_ready;
  assign if_ready = (state_q == ST_RUN) && !stall_c && !flush;
  assign accept_c = if_valid && if_ready;

  // Load in ID/EX whose result the incoming word needs next cycle.
  assign lu_hazard_c = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) &&
                       ((rs_c == ex_q.dest) || (dec_c.rt_used && (rt_c == ex_q.dest)));

  reg_file_2r1w #(
    .DW    (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_we),
    .waddr   (wb_waddr),
    .wdata   (wb_wdata),
    .raddr_a (rs_c),
    .raddr_b (rt_c),
    .rdata_a (rf_a_c),
    .rdata_b (rf_b_c)
  );

  // Operand forwarding: EX/MEM result beats the register file (which already bypasses WB).
  always_comb begin
    opnd_a_c = rf_a_c;
    opnd_b_c = rf_b_c;
    if (mem_we && (mem_waddr == rs_c) && (rs_c != '0)) opnd_a_c = mem_wdata;
    if (mem_we && (mem_waddr == rt_c) && (rt_c != '0)) opnd_b_c = mem_wdata;
  end

  // ID/EX record for the word in decode; illegal words go down as a NOP.
  always_comb begin
    issue_c           = IDEX_RST;
    issue_c.valid     = 1'b1;
    issue_c.instr     = dec_c.illegal ? RST_INSTR : id_instr_c;
    issue_c.reg_a     = opnd_a_c;
    issue_c.reg_b     = opnd_b_c;
    issue_c.dest      = dec_c.dest;
    issue_c.we        = dec_c.we;
    issue_c.mem_read  = dec_c.mem_read;
    issue_c.mem_write = dec_c.mem_write;
    issue_c.illegal   = dec_c.illegal;
  end

  // Hazard FSM and ID/EX next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ex_d    = ex_q;
    if (flush) begin
      ex_d    = IDEX_RST;
      hold_d  = RST_INSTR;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_LU_STALL: begin
          ex_d    = issue_c;
          state_d = ST_RUN;
        end
        default: begin
          if (stall_c) begin
            ex_d = ex_q;
          end else if (accept_c && lu_hazard_c) begin
            ex_d    = IDEX_RST;
            hold_d  = if_instr;
            state_d = ST_LU_STALL;
          end else if (accept_c) begin
            ex_d = issue_c;
          end else begin
            ex_d = IDEX_RST;
          end
        end
      endcase
    end
  end

  // State, hold and ID/EX registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      hold_q  <= RST_INSTR;
      ex_q    <= IDEX_RST;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_instr     = ex_q.instr;
  assign ex_reg_a     = ex_q.reg_a;
  assign ex_reg_b     = ex_q.reg_b;
  assign ex_dest      = ex_q.dest;
  assign ex_we        = ex_q.we;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: cycle model of the issue rules plus directed checks.
module tb_id_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, if_ready, flush, ex_ready;
  logic [31:0] if_instr;
  logic        mem_we, wb_we;
  logic [4:0]  mem_waddr, wb_waddr;
  logic [31:0] mem_wdata, wb_wdata;
  logic        ex_valid, ex_we, ex_mem_read, ex_mem_write, ex_illegal;
  logic [31:0] ex_instr, ex_reg_a, ex_reg_b;
  logic [4:0]  ex_dest;

  always #5 clk = ~clk;

  id_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .flush(flush), .ex_ready(ex_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_reg_a(ex_reg_a), .ex_reg_b(ex_reg_b),
    .ex_dest(ex_dest), .ex_we(ex_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        we;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: expected ID/EX contents, architectural registers, pending stalled word.
  exp_t        e = '0;
  logic [31:0] m_rf [32];
  bit          m_hold_pend = 0;
  logic [31:0] m_hold = '0;
  bit          started = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_val(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (mem_we && mem_waddr == r) return mem_wdata;
    if (wb_we && wb_waddr == r) return wb_wdata;
    return m_rf[r];
  endfunction

  function automatic bit rt_is_src(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return (op == 6'h00) || (op inside {6'h2B, 6'h04, 6'h05});
  endfunction

  function automatic exp_t expect_issue(input logic [31:0] w);
    exp_t       x;
    logic [5:0] op, fn;
    bit         wr_rd, wr_rt, legal;
    op    = w[31:26];
    fn    = w[5:0];
    wr_rd = (op == 6'h00) &&
            (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B});
    wr_rt = op inside {[6'h08:6'h0F], 6'h23};
    legal = wr_rd || wr_rt || (op inside {6'h2B, 6'h04, 6'h05});
    x       = '0;
    x.valid = 1'b1;
    x.instr = legal ? w : 32'h0;
    x.a     = src_val(w[25:21]);
    x.b     = src_val(w[20:16]);
    x.dest  = wr_rd ? w[15:11] : (wr_rt ? w[20:16] : 5'd0);
    x.we    = (x.dest != 5'd0);
    x.mr    = (op == 6'h23);
    x.mw    = (op == 6'h2B);
    x.ill   = !legal;
    return x;
  endfunction

  function automatic bit load_use(input logic [31:0] w);
    return e.valid && e.mr && (e.dest != 5'd0) &&
           ((w[25:21] == e.dest) || (rt_is_src(w) && (w[20:16] == e.dest)));
  endfunction

  function automatic bit m_ready();
    return !m_hold_pend && (ex_ready || !e.valid) && !flush;
  endfunction

  // Model update on each rising edge from the inputs presented in that cycle.
  always @(posedge clk) begin : model
    bit acc;
    started = 1;
    if (!rst_n) begin
      e           = '0;
      m_hold_pend = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      acc = if_valid && m_ready();
      if (flush) begin
        e           = '0;
        m_hold_pend = 0;
      end else if (m_hold_pend) begin
        e           = expect_issue(m_hold);
        m_hold_pend = 0;
      end else if (e.valid && !ex_ready) begin
        e = e;
      end else if (acc && load_use(if_instr)) begin
        e           = '0;
        m_hold      = if_instr;
        m_hold_pend = 1;
      end else if (acc) begin
        e = expect_issue(if_instr);
      end else begin
        e = '0;
      end
      if (wb_we && wb_waddr != 5'd0) m_rf[wb_waddr] = wb_wdata;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    #2;
    if (started) begin
      chk("idex", {ex_valid, ex_instr, ex_reg_a, ex_reg_b, ex_dest, ex_we, ex_mem_read,
                   ex_mem_write, ex_illegal}, e);
      chk("if_ready", if_ready, m_ready());
    end
  end

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  task automatic put(input logic [31:0] w);
    if_valid = 1'b1;
    if_instr = w;
    cyc();
    if_valid = 1'b0;
  endtask

  localparam logic [31:0] ADD3    = 32'h00221820;
  localparam logic [31:0] OR4     = 32'h00222025;
  localparam logic [31:0] LW8     = 32'h8C280000;
  localparam logic [31:0] ADD9    = 32'h01024820;
  localparam logic [31:0] ADD_RD0 = 32'h00220020;
  localparam logic [31:0] ADD5_00 = 32'h00002820;

  logic [31:0] tbl [12];
  int          idx;
  bit          acc_s;

  initial begin
    tbl = '{32'h8C280004, 32'h01024820, 32'hAD280008, 32'h8C6A0000, 32'hAC8A0000,
            32'h3C0B1234, 32'h11600008, 32'h000B6100, 32'h358D00FF, 32'h00221801,
            32'h8C200000, 32'h00001820};
    rst_n = 0; if_valid = 0; if_instr = '0; flush = 0; ex_ready = 1;
    mem_we = 0; mem_waddr = '0; mem_wdata = '0; wb_we = 0; wb_waddr = '0; wb_wdata = '0;

    // Reset
    cyc(); cyc();
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_instr", ex_instr, 32'h0);
    rst_n = 1;
    chk("rst_if_ready", if_ready, 1'b1);

    // Register file write then plain R-type issue
    wb_we = 1; wb_waddr = 5'd1; wb_wdata = 32'h12FD; cyc();
    wb_waddr = 5'd2; wb_wdata = 32'h16F2; cyc();
    wb_we = 0;
    put(ADD3);
    chk("add_reg_a", ex_reg_a, 32'h12FD);
    chk("add_reg_b", ex_reg_b, 32'h16F2);
    chk("add_dest", ex_dest, 5'd3);
    chk("add_we", ex_we, 1'b1);

    // EX/MEM beats WB for the same source
    mem_we = 1; mem_waddr = 5'd1; mem_wdata = 32'hAAAA;
    wb_we = 1; wb_waddr = 5'd1; wb_wdata = 32'h5555;
    put(ADD3);
    chk("fwd_mem_over_wb", ex_reg_a, 32'hAAAA);
    mem_we = 0; wb_we = 0;

    // Load-use bubble then forwarded issue
    put(LW8);
    chk("lw_mem_read", ex_mem_read, 1'b1);
    chk("lw_dest", ex_dest, 5'd8);
    if_valid = 1; if_instr = ADD9; cyc(); if_valid = 0;
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_if_ready", if_ready, 1'b0);
    mem_we = 1; mem_waddr = 5'd8; mem_wdata = 32'hBEEF; cyc(); mem_we = 0;
    chk("lu_issue_valid", ex_valid, 1'b1);
    chk("lu_issue_instr", ex_instr, ADD9);
    chk("lu_issue_a", ex_reg_a, 32'hBEEF);
    chk("lu_issue_b", ex_reg_b, 32'h16F2);

    // Back-pressure hold, then flush during the stall
    put(ADD3);
    ex_ready = 0; if_valid = 1; if_instr = OR4;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_instr", ex_instr, ADD3);
      chk("stall_valid", ex_valid, 1'b1);
      chk("stall_if_ready", if_ready, 1'b0);
    end
    flush = 1;
    #1 chk("flush_if_ready", if_ready, 1'b0);
    cyc();
    flush = 0; ex_ready = 1; if_valid = 0;
    chk("flush_valid", ex_valid, 1'b0);
    cyc();
    chk("flush_no_accept", ex_valid, 1'b0);

    // Illegal opcode, rd=0 and $0 operands
    put(32'hFC000000);
    chk("ill_flag", ex_illegal, 1'b1);
    chk("ill_we", ex_we, 1'b0);
    chk("ill_instr", ex_instr, 32'h0);
    put(ADD_RD0);
    chk("rd0_ill", ex_illegal, 1'b0);
    chk("rd0_we", ex_we, 1'b0);
    mem_we = 1; mem_waddr = 5'd0; mem_wdata = 32'hDEAD;
    wb_we = 1; wb_waddr = 5'd0; wb_wdata = 32'hBEEF;
    put(ADD5_00);
    chk("zero_a", ex_reg_a, 32'h0);
    chk("zero_b", ex_reg_b, 32'h0);
    mem_we = 0; wb_we = 0;
    put(ADD5_00);
    chk("zero_rf_a", ex_reg_a, 32'h0);

    // Reset while in the load-use stall drops the held word
    put(LW8);
    if_valid = 1; if_instr = ADD9; cyc(); if_valid = 0;
    rst_n = 0; cyc(); rst_n = 1;
    chk("rst_stall_valid", ex_valid, 1'b0);
    cyc();
    chk("rst_stall_dropped", ex_valid, 1'b0);

    // Mixed stream with side traffic and intermittent back-pressure
    idx = 0;
    for (int g = 0; g < 60 && idx < 12; g++) begin
      if_valid = 1; if_instr = tbl[idx];
      ex_ready = (g % 5) != 3;
      wb_we = 1; wb_waddr = 5'(g % 9 + 1); wb_wdata = 32'h1000 + 32'(g);
      mem_we = g[0]; mem_waddr = 5'(g % 12); mem_wdata = 32'hA000 + 32'(g);
      #1 acc_s = if_ready;
      cyc();
      if (acc_s) idx++;
    end
    if_valid = 0; wb_we = 0; mem_we = 0; ex_ready = 1;
    chk("stream_drained", idx, 12);
    cyc(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
